// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, instruction classes,
// opcodes, ALU control codes and datapath select values.
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_ILLEGAL = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R_ALU  = 4'd0,
        C_I_ALU  = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_LUI    = 4'd5,
        C_AUIPC  = 4'd6,
        C_JAL    = 4'd7,
        C_ILL    = 4'd8
    } iclass_t;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2,
        BR_GE = 2'd3
    } br_cond_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU control codes shared with the ALU; MOVEA passes operand A through.
    localparam logic [3:0] ALU_CTRL_ADD   = 4'd0;
    localparam logic [3:0] ALU_CTRL_ADDU  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SUB   = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLL   = 4'd3;
    localparam logic [3:0] ALU_CTRL_LUI   = 4'd4;
    localparam logic [3:0] ALU_CTRL_AUIPC = 4'd5;
    localparam logic [3:0] ALU_CTRL_MOVEA = 4'd15;

    localparam logic [1:0] SRC_A_RS1    = 2'd0;
    localparam logic [1:0] SRC_A_PC     = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JAL    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic br_taken(input br_cond_t cond, input logic zero,
                                      input logic lt, input logic ge);
        case (cond)
            BR_EQ:   return zero;
            BR_NE:   return !zero;
            BR_LT:   return lt;
            default: return ge;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_instr_class_dec.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] to class,
// execute-stage ALU code, immediate format and branch condition.
module instr_class_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output iclass_t    iclass,
    output logic [3:0] alu_ctrl,
    output logic [2:0] imm_sel,
    output br_cond_t   br_cond
);

    always_comb begin
        iclass   = C_ILL;
        alu_ctrl = ALU_CTRL_ADD;
        imm_sel  = IMM_I;
        br_cond  = BR_EQ;
        case (opcode)
            OP_R: begin
                if (funct3 == 3'd0) begin
                    iclass   = C_R_ALU;
                    alu_ctrl = funct7_5 ? ALU_CTRL_SUB : ALU_CTRL_ADD;
                end else if (funct3 == 3'd1) begin
                    iclass   = C_R_ALU;
                    alu_ctrl = ALU_CTRL_SLL;
                end
            end
            OP_I: begin
                if (funct3 == 3'd0) begin
                    iclass = C_I_ALU;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'd2) begin
                    iclass = C_LOAD;
                end
            end
            OP_STORE: begin
                imm_sel = IMM_S;
                if (funct3 == 3'd2) begin
                    iclass = C_STORE;
                end
            end
            OP_BRANCH: begin
                imm_sel  = IMM_B;
                alu_ctrl = ALU_CTRL_SUB;
                case (funct3)
                    3'd0: begin iclass = C_BRANCH; br_cond = BR_EQ; end
                    3'd1: begin iclass = C_BRANCH; br_cond = BR_NE; end
                    3'd4: begin iclass = C_BRANCH; br_cond = BR_LT; end
                    3'd5: begin iclass = C_BRANCH; br_cond = BR_GE; end
                    default: iclass = C_ILL;
                endcase
            end
            OP_LUI: begin
                iclass   = C_LUI;
                alu_ctrl = ALU_CTRL_LUI;
                imm_sel  = IMM_U;
            end
            OP_AUIPC: begin
                iclass   = C_AUIPC;
                alu_ctrl = ALU_CTRL_AUIPC;
                imm_sel  = IMM_U;
            end
            OP_JAL: begin
                iclass  = C_JAL;
                imm_sel = IMM_J;
            end
            default: iclass = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU control and operand selects, and counts retired instructions.
//
// state     | meaning
// S_FETCH   | imem request, pc+4 in ALU; IR/PC load on imem_ready
// S_DECODE  | classify IR, latch class/alu code/imm format
// S_EXEC    | ALU op per class; branches and jal resolve here
// S_MEM     | dmem request for lw/sw
// S_WB      | register file write
// S_ILLEGAL | flag illegal instruction
// S_HALT    | parked until rst
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             lt,
    input  logic             ge,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       state_dbg
);

    localparam int WAIT_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int WAIT_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              wait_expired;
    logic              retire;
    logic              set_illegal;
    logic              set_mem_err;

    iclass_t    dec_cls, cls_q;
    logic [3:0] dec_alu, alu_q;
    logic [2:0] dec_imm, imm_q;
    br_cond_t   dec_br, br_q;

    instr_class_dec u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .iclass   (dec_cls),
        .alu_ctrl (dec_alu),
        .imm_sel  (dec_imm),
        .br_cond  (dec_br)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            retired_cnt <= '0;
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
            cls_q       <= C_ILL;
            alu_q       <= ALU_CTRL_ADD;
            imm_q       <= IMM_I;
            br_q        <= BR_EQ;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
            if (state == S_DECODE) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
                imm_q <= dec_imm;
                br_q  <= dec_br;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_mem_err) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Ready in the same cycle the limit is reached takes priority over the timeout.
    always_comb begin
        state_nxt    = state;
        wait_inc     = 1'b0;
        wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
        retire       = 1'b0;
        set_illegal  = 1'b0;
        set_mem_err  = 1'b0;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        alu_ctrl     = ALU_CTRL_MOVEA;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        imm_sel      = imm_q;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req  = 1'b1;
                    alu_ctrl  = ALU_CTRL_ADDU;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    if (imem_ready) begin
                        ir_load   = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (wait_expired) begin
                        set_mem_err = 1'b1;
                        state_nxt   = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_DECODE: begin
                    imm_sel = dec_imm;
                    if (dec_cls == C_ILL) begin
                        set_illegal = 1'b1;
                        state_nxt   = S_ILLEGAL;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_ctrl = alu_q;
                    case (cls_q)
                        C_R_ALU: state_nxt = S_WB;
                        C_I_ALU: begin
                            alu_src_b = SRC_B_IMM;
                            state_nxt = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_b = SRC_B_IMM;
                            state_nxt = S_MEM;
                        end
                        C_LUI: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = SRC_B_IMM;
                            state_nxt = S_WB;
                        end
                        C_AUIPC: begin
                            alu_src_a = SRC_A_OLD_PC;
                            alu_src_b = SRC_B_IMM;
                            state_nxt = S_WB;
                        end
                        C_BRANCH: begin
                            pc_write  = br_taken(br_q, zero, lt, ge);
                            pc_src    = PC_SRC_BRANCH;
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                        C_JAL: begin
                            alu_src_a = SRC_A_OLD_PC;
                            alu_src_b = SRC_B_IMM;
                            pc_write  = 1'b1;
                            pc_src    = PC_SRC_JAL;
                            reg_write = 1'b1;
                            wb_sel    = WB_PC4;
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                        default: state_nxt = S_HALT;
                    endcase
                end
                S_MEM: begin
                    alu_ctrl  = alu_q;
                    alu_src_b = SRC_B_IMM;
                    dmem_req  = 1'b1;
                    dmem_we   = (cls_q == C_STORE);
                    if (dmem_ready) begin
                        if (cls_q == C_STORE) begin
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end else if (wait_expired) begin
                        set_mem_err = 1'b1;
                        state_nxt   = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_WB: begin
                    alu_ctrl  = alu_q;
                    reg_write = 1'b1;
                    wb_sel    = (cls_q == C_LOAD) ? WB_MEM : WB_ALU;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_ILLEGAL: state_nxt = S_HALT;
                S_HALT:    state_nxt = S_HALT;
                default:   state_nxt = S_HALT;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: table of instruction vectors with a
// scoreboard of expected per-instruction results, plus reset/halt/timeout sequences.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int NEVER       = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7_5 = 1'b0;
    logic             zero = 1'b0, lt = 1'b0, ge = 1'b0;
    logic             imem_ready = 1'b0, dmem_ready = 1'b0;
    logic             imem_req, ir_load, pc_write, reg_write, dmem_req, dmem_we;
    logic [3:0]       alu_ctrl;
    logic [1:0]       alu_src_a, alu_src_b, pc_src, wb_sel;
    logic [2:0]       imm_sel, state_dbg;
    logic             illegal, mem_err;
    logic [CNT_W-1:0] retired_cnt;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ge(ge), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .illegal(illegal), .mem_err(mem_err), .retired_cnt(retired_cnt), .state_dbg(state_dbg)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic [2:0] flg;      // {zero, lt, ge}
        int         iw, dw;   // wait cycles before imem/dmem ready
        int         cyc, imc, fstb;
        bit         src_chk;
        logic [3:0] alu;
        logic [1:0] a, b;
        bit         imm_chk;
        logic [2:0] imm;
        logic       pcw;
        logic [1:0] pcs;
        int         rw;
        logic [1:0] wbs;
        int         memc, wec;
        logic       retire;
        logic [2:0] end_st;
    } vec_t;

    typedef struct {
        int         cyc, imc, fstb, rw, memc, wec;
        logic [3:0] alu;
        logic [1:0] a, b, pcs, wbs;
        logic [2:0] imm, end_st;
        logic       pcw;
        logic [CNT_W-1:0] ret;
    } obs_t;

    vec_t             vecs[$];
    vec_t             exp_q[$];
    logic [CNT_W-1:0] ret_q[$];
    logic [CNT_W-1:0] model_ret = '0;
    int               checks = 0;
    int               failures = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [2:0] f3,
            input logic f75, input logic [2:0] flg, input int iw, input int dw,
            input int cyc, input int imc, input int fstb,
            input bit src_chk, input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
            input bit imm_chk, input logic [2:0] imm, input logic pcw, input logic [1:0] pcs,
            input int rw, input logic [1:0] wbs, input int memc, input int wec,
            input logic retire, input logic [2:0] end_st);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = f3; v.f75 = f75; v.flg = flg; v.iw = iw; v.dw = dw;
        v.cyc = cyc; v.imc = imc; v.fstb = fstb; v.src_chk = src_chk; v.alu = alu;
        v.a = a; v.b = b; v.imm_chk = imm_chk; v.imm = imm; v.pcw = pcw; v.pcs = pcs;
        v.rw = rw; v.wbs = wbs; v.memc = memc; v.wec = wec; v.retire = retire; v.end_st = end_st;
        return v;
    endfunction

    task automatic compare(input obs_t o);
        vec_t             e;
        logic [CNT_W-1:0] r;
        if (exp_q.size() == 0) begin
            check("scoreboard empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        r = ret_q.pop_front();
        check({e.name, " cycles"}, o.cyc, e.cyc);
        check({e.name, " imem_req cycles"}, o.imc, e.imc);
        check({e.name, " fetch strobes"}, o.fstb, e.fstb);
        check({e.name, " exec pc_write"}, int'(o.pcw), int'(e.pcw));
        check({e.name, " reg_write cycles"}, o.rw, e.rw);
        check({e.name, " dmem_req cycles"}, o.memc, e.memc);
        check({e.name, " dmem_we cycles"}, o.wec, e.wec);
        check({e.name, " end state"}, int'(o.end_st), int'(e.end_st));
        check({e.name, " retired_cnt"}, int'(o.ret), int'(r));
        if (e.src_chk) begin
            check({e.name, " exec alu_ctrl"}, int'(o.alu), int'(e.alu));
            check({e.name, " exec src_a"}, int'(o.a), int'(e.a));
            check({e.name, " exec src_b"}, int'(o.b), int'(e.b));
        end
        if (e.imm_chk) check({e.name, " exec imm_sel"}, int'(o.imm), int'(e.imm));
        if (e.pcw) check({e.name, " exec pc_src"}, int'(o.pcs), int'(e.pcs));
        if (e.rw > 0) check({e.name, " wb_sel"}, int'(o.wbs), int'(e.wbs));
    endtask

    task automatic run_vec(input vec_t v);
        obs_t       o;
        bit         left_fetch, done;
        int         fcnt, mcnt;
        logic [2:0] st;
        exp_q.push_back(v);
        if (v.retire) model_ret = model_ret + CNT_W'(1);
        ret_q.push_back(model_ret);
        o = '{default: 0};
        left_fetch = 0; done = 0; fcnt = 0; mcnt = 0;
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f75;
        {zero, lt, ge} = v.flg;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            st = state_dbg;
            imem_ready = (st == S_FETCH) && (fcnt == v.iw);
            dmem_ready = (st == S_MEM) && (mcnt == v.dw);
            #1;
            o.cyc++;
            if (st != S_FETCH) left_fetch = 1;
            if (st == S_FETCH) fcnt++;
            if (st == S_MEM) mcnt++;
            if (imem_req) o.imc++;
            if (ir_load && pc_write && pc_src == PC_SRC_ALU) o.fstb++;
            if (dmem_req) o.memc++;
            if (dmem_we) o.wec++;
            if (reg_write) begin
                o.rw++;
                o.wbs = wb_sel;
            end
            if (st == S_EXEC) begin
                o.alu = alu_ctrl; o.a = alu_src_a; o.b = alu_src_b;
                o.imm = imm_sel; o.pcw = pc_write; o.pcs = pc_src;
            end
            @(posedge clk);
            #1;
            if (state_dbg == S_HALT || (left_fetch && state_dbg == S_FETCH)) done = 1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (!done) check({v.name, " completion within budget"}, 0, 1);
        o.end_st = state_dbg;
        o.ret = retired_cnt;
        compare(o);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({nm, " strobes low under rst"},
              int'({imem_req, ir_load, pc_write, reg_write, dmem_req, dmem_we}), 0);
        check({nm, " alu_ctrl under rst"}, int'(alu_ctrl), int'(ALU_CTRL_MOVEA));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check({nm, " state after rst"}, int'(state_dbg), int'(S_FETCH));
        check({nm, " imem_req after rst"}, int'(imem_req), 1);
        check({nm, " retired after rst"}, int'(retired_cnt), 0);
        check({nm, " sticky flags after rst"}, int'({illegal, mem_err}), 0);
        model_ret = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        //           name     op         f3 f75 flg    iw dw  cyc imc fs src alu             a             b           ic imm   pcw pcs            rw wbs     mc wc rt end
        vecs.push_back(mk("add",   OP_R,      0, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("sub",   OP_R,      0, 1, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("sll",   OP_R,      1, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_SLL,   SRC_A_RS1,    SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("addi",  OP_I,      0, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_IMM, 1, IMM_I, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("lw_w3", OP_LOAD,   2, 0, 3'b000, 0, 3, 8, 1, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_IMM, 1, IMM_I, 0, PC_SRC_ALU,    1, WB_MEM, 4, 0, 1, S_FETCH));
        vecs.push_back(mk("sw",    OP_STORE,  2, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_IMM, 1, IMM_S, 0, PC_SRC_ALU,    0, WB_ALU, 1, 1, 1, S_FETCH));
        vecs.push_back(mk("sw_w2", OP_STORE,  2, 0, 3'b000, 0, 2, 6, 1, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_IMM, 1, IMM_S, 0, PC_SRC_ALU,    0, WB_ALU, 3, 3, 1, S_FETCH));
        vecs.push_back(mk("beq_t", OP_BRANCH, 0, 0, 3'b100, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 1, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("beq_n", OP_BRANCH, 0, 0, 3'b011, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 0, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("bne_t", OP_BRANCH, 1, 0, 3'b000, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 1, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("bne_n", OP_BRANCH, 1, 0, 3'b111, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 0, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("blt_t", OP_BRANCH, 4, 0, 3'b010, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 1, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("blt_n", OP_BRANCH, 4, 0, 3'b101, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 0, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("bge_t", OP_BRANCH, 5, 0, 3'b001, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 1, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("bge_n", OP_BRANCH, 5, 0, 3'b110, 0, 0, 3, 1, 1, 1, ALU_CTRL_SUB,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_B, 0, PC_SRC_BRANCH, 0, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("lui",   OP_LUI,    0, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_LUI,   SRC_A_ZERO,   SRC_B_IMM, 1, IMM_U, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("auipc", OP_AUIPC,  0, 0, 3'b000, 0, 0, 4, 1, 1, 1, ALU_CTRL_AUIPC, SRC_A_OLD_PC, SRC_B_IMM, 1, IMM_U, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("jal",   OP_JAL,    0, 0, 3'b000, 0, 0, 3, 1, 1, 0, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_RS2, 1, IMM_J, 1, PC_SRC_JAL,    1, WB_PC4, 0, 0, 1, S_FETCH));
        vecs.push_back(mk("add_i3",OP_R,      0, 0, 3'b000, 3, 0, 7, 4, 1, 1, ALU_CTRL_ADD,   SRC_A_RS1,    SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU,    1, WB_ALU, 0, 0, 1, S_FETCH));

        do_reset("power-on");
        foreach (vecs[i]) run_vec(vecs[i]);
        check("no mem_err after boundary ready", int'(mem_err), 0);
        check("no illegal after legal table", int'(illegal), 0);

        // sw interrupted by reset while waiting in S_MEM
        opcode = OP_STORE; funct3 = 3'd2; funct7_5 = 1'b0; {zero, lt, ge} = 3'b000;
        n = 0;
        while (state_dbg != S_MEM && n < 20) begin
            @(negedge clk);
            imem_ready = (state_dbg == S_FETCH);
            @(posedge clk);
            #1;
            n++;
        end
        check("sw reaches S_MEM", int'(state_dbg == S_MEM), 1);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check("sw dmem_req/we before rst", int'({dmem_req, dmem_we}), 3);
        do_reset("sw mid-mem");

        run_vec(mk("illegal", 7'b1111111, 0, 0, 3'b000, 0, 0, 3, 1, 1, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU, 0, WB_ALU, 0, 0, 0, S_HALT));
        check("illegal flag set", int'(illegal), 1);
        check("mem_err clear on illegal", int'(mem_err), 0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            #1;
            if (state_dbg != S_HALT || imem_req || ir_load || pc_write || reg_write || dmem_req || dmem_we)
                bad++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check("halt holds with strobes low", bad, 0);
        do_reset("after illegal");

        run_vec(mk("imem_tmo", OP_R, 0, 0, 3'b000, NEVER, 0, 4, 4, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_RS2, 0, IMM_I, 0, PC_SRC_ALU, 0, WB_ALU, 0, 0, 0, S_HALT));
        check("mem_err after imem timeout", int'(mem_err), 1);
        check("illegal clear on timeout", int'(illegal), 0);
        do_reset("after imem timeout");

        run_vec(mk("dmem_tmo", OP_LOAD, 2, 0, 3'b000, 0, NEVER, 7, 1, 1, 1, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_IMM, 1, IMM_I, 0, PC_SRC_ALU, 0, WB_ALU, 4, 0, 0, S_HALT));
        check("mem_err after dmem timeout", int'(mem_err), 1);
        do_reset("after dmem timeout");

        check("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
